mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 16-bit pipeline, directly downstream of execute.
- Captures the ALU result, store data and write-back control, then performs at most one data-memory access per instruction over a level request/ready handshake.
- Stalls upstream while an access is outstanding and presents a registered write-back result with a one-cycle valid strobe.
- Bounds every access with a timeout that raises a sticky error.

Parameters:
- MAX_WAIT, 255: max BUSY cycles without dmem_ready before timeout; range 1..65535.
- DW, 16: datapath width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute presents an instruction this cycle.
- ALU_out  in  DW  execute result; the memory address for load/store.
- store_data  in  DW  register operand written on store.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- reg_write  in  1  instruction writes the register file.
- wb_reg  in  3  destination register index.
- stall  out  1  upstream must hold; in_valid is ignored while high.
- out_valid  out  1  write-back fields valid this cycle.
- wb_data  out  DW  load data, else ALU result.
- wb_reg_out  out  3  registered destination index.
- reg_write_out  out  1  registered reg_write; forced 0 on store.
- dmem_en  out  1  access request, level-held until ready.
- dmem_wr  out  1  1 = write, 0 = read.
- dmem_addr  out  DW  access address.
- dmem_wdata  out  DW  write data.
- dmem_rdata  in  DW  read data, valid when dmem_ready.
- dmem_ready  in  1  access completes this cycle.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; every output 0, including dmem_en; timer 0; err cleared. Reset mid-access abandons the access immediately.
- Capture: when in_valid and !stall, latch all inputs.
- FSM states:
  - IDLE: wait for a capture.
  - BUSY: memory access outstanding.
  - DONE: write-back result presented.
  - ERR: terminal error state.
- Transitions on capture (from IDLE or DONE):
  - No memory op → DONE.
  - mem_read xor mem_write → BUSY.
  - mem_read and mem_write both set → ERR.
- No capture: IDLE stays IDLE; DONE returns to IDLE.
- BUSY outputs: dmem_en=1; dmem_addr, dmem_wdata and dmem_wr driven from the latch and stable until dmem_ready.
- BUSY exit on dmem_ready (including the first BUSY cycle) → DONE. Load data is registered into wb_data.
- BUSY timeout: timer counts BUSY cycles. Timer reaching MAX_WAIT with no dmem_ready → ERR.
- stall = 1 in BUSY and ERR, else 0. DONE accepts a new instruction, giving ALU ops a throughput of 1 per cycle with 1-cycle latency.
- Memory op latency: capture → DONE = (cycles to dmem_ready) + 1.
- out_valid = (state == DONE).
- wb_data in DONE:
  - load: registered dmem_rdata.
  - otherwise: latched ALU_out.
- wb_reg_out / reg_write_out are valid whenever out_valid is high; reg_write_out = 0 for stores.
- ERR: err=1, stall=1, dmem_en=0; exits only through reset.
- dmem_ready outside BUSY is ignored.
- Address arithmetic: none; ALU_out is passed through unmodified (except as gated by the optional feature).

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a captured memory op with ALU_out[0]=1 goes to ERR with no dmem request.
- Undefined: no alignment check; odd addresses go to dmem unchanged, and memory ignores bit 0.

Decomposition:
- Shared package mem_stage_pkg:
  - state enum {IDLE, BUSY, DONE, ERR};
  - DW default;
  - timer width = $clog2(MAX_WAIT+1).
- One natural sub-module: mem_wait_timer.
  - Clears on entry to BUSY and increments each BUSY cycle.
  - Flags expiry at MAX_WAIT.
  - Shares clk and rst.

Test Plan:
- ALU op: in_valid with ALU_out=16'h1234, reg_write=1, wb_reg=3, no mem op → next cycle out_valid=1, wb_data=16'h1234, wb_reg_out=3, stall=0 throughout. Three back-to-back ALU ops → three consecutive out_valid cycles.
- Load with dmem_ready 4 cycles after request: ALU_out=16'h0040, dmem_rdata=16'hBEEF → dmem_en high 4 cycles with addr 16'h0040, stall high in the same cycles, then out_valid=1, wb_data=16'hBEEF.
- Store: ALU_out=16'h0010, store_data=16'h00AA, ready on first BUSY cycle → dmem_wr=1, dmem_wdata=16'h00AA for 1 cycle, then out_valid=1 with reg_write_out=0.
- Timeout: MAX_WAIT=8, dmem_ready held 0 → after 8 BUSY cycles err=1, dmem_en=0, stall stays 1. A new in_valid is ignored; rst low returns to IDLE with err=0.
- Reset mid-load (BUSY cycle 2) → dmem_en, stall and out_valid drop asynchronously. A late dmem_ready after release causes no out_valid.
- mem_read=mem_write=1 → ERR the next cycle. With MEM_ALIGN_CHECK_EN, a load at 16'h0041 → ERR with dmem_en never asserted.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and sizing helpers for the memory stage and its wait timer.
package mem_stage_pkg;

    localparam int unsigned DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    function automatic int unsigned timer_width(input int unsigned max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on dmem_ready; flags the last permitted BUSY cycle.
module mem_wait_timer
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    output logic expired
);

    localparam int unsigned   TW   = timer_width(MAX_WAIT);
    localparam logic [TW-1:0] LAST = TW'(MAX_WAIT - 1);

    logic [TW-1:0] count_q, count_d;

    // count_q holds the number of BUSY cycles already completed
    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = '0;
        end else if (busy && (count_q != LAST)) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = busy && (count_q == LAST);

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: one data-memory access per instruction with a bounded wait.
// Define MEM_ALIGN_CHECK_EN to trap memory ops at odd addresses into ERR.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned DW       = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] ALU_out,
    input  logic [DW-1:0] store_data,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          reg_write,
    input  logic [2:0]    wb_reg,
    output logic          stall,
    output logic          out_valid,
    output logic [DW-1:0] wb_data,
    output logic [2:0]    wb_reg_out,
    output logic          reg_write_out,
    output logic          dmem_en,
    output logic          dmem_wr,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ready,
    output logic          err
);

    state_t        state_q, state_d;
    logic [DW-1:0] addr_q, wdata_q, rdata_q;
    logic [2:0]    wb_reg_q;
    logic          rd_q, wr_q, rw_q;
    logic          capture, is_mem, bad_op, busy, expired, enter_busy;

    assign busy    = (state_q == BUSY);
    assign capture = in_valid && !stall;
    assign is_mem  = mem_read ^ mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_op = (mem_read && mem_write) || (is_mem && ALU_out[0]);
`else
    assign bad_op = mem_read && mem_write;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (!capture) begin
                    state_d = IDLE;
                end else if (bad_op) begin
                    state_d = ERR;
                end else if (is_mem) begin
                    state_d = BUSY;
                end else begin
                    state_d = DONE;
                end
            end
            BUSY: begin
                // ready wins over expiry on the final permitted cycle
                if (dmem_ready) begin
                    state_d = DONE;
                end else if (expired) begin
                    state_d = ERR;
                end
            end
            ERR: state_d = ERR;
        endcase
    end

    assign enter_busy = (state_d == BUSY) && !busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wb_reg_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rw_q     <= 1'b0;
        end else begin
            if (capture) begin
                addr_q   <= ALU_out;
                wdata_q  <= store_data;
                wb_reg_q <= wb_reg;
                rd_q     <= mem_read;
                wr_q     <= mem_write;
                rw_q     <= reg_write;
            end
            if (busy && dmem_ready && rd_q) begin
                rdata_q <= dmem_rdata;
            end
        end
    end

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (enter_busy),
        .busy    (busy),
        .expired (expired)
    );

    assign stall         = busy || (state_q == ERR);
    assign err           = (state_q == ERR);
    assign out_valid     = (state_q == DONE);
    assign wb_data       = out_valid ? (rd_q ? rdata_q : addr_q) : '0;
    assign wb_reg_out    = out_valid ? wb_reg_q : 3'd0;
    assign reg_write_out = out_valid && rw_q && !wr_q;
    assign dmem_en       = busy;
    assign dmem_wr       = busy && wr_q;
    assign dmem_addr     = busy ? addr_q : '0;
    assign dmem_wdata    = busy ? wdata_q : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized reference-model run.
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int unsigned DW       = 16;
    localparam int unsigned MAX_WAIT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] ALU_out, store_data;
    logic          mem_read, mem_write, reg_write;
    logic [2:0]    wb_reg;
    logic          stall, out_valid;
    logic [DW-1:0] wb_data;
    logic [2:0]    wb_reg_out;
    logic          reg_write_out;
    logic          dmem_en, dmem_wr;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          dmem_ready;
    logic          err;

    int checks = 0;
    int errors = 0;

    mem_stage #(
        .MAX_WAIT (MAX_WAIT),
        .DW       (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .ALU_out       (ALU_out),
        .store_data    (store_data),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .wb_reg        (wb_reg),
        .stall         (stall),
        .out_valid     (out_valid),
        .wb_data       (wb_data),
        .wb_reg_out    (wb_reg_out),
        .reg_write_out (reg_write_out),
        .dmem_en       (dmem_en),
        .dmem_wr       (dmem_wr),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ready    (dmem_ready),
        .err           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        ALU_out    = '0;
        store_data = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        wb_reg     = 3'd0;
        dmem_rdata = '0;
        dmem_ready = 1'b0;
    endtask

    task automatic issue(input logic [DW-1:0] alu, input logic [DW-1:0] sd, input logic rd,
                         input logic wr, input logic rw, input logic [2:0] rg);
        in_valid   = 1'b1;
        ALU_out    = alu;
        store_data = sd;
        mem_read   = rd;
        mem_write  = wr;
        reg_write  = rw;
        wb_reg     = rg;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [56:0] outs;
        rst = 1'b0;
        idle_inputs();
        #1;
        outs = {stall, out_valid, wb_data, wb_reg_out, reg_write_out, dmem_en, dmem_wr,
                dmem_addr, dmem_wdata, err};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        step();
        rst = 1'b1;
        step();
        outs = {stall, out_valid, wb_data, wb_reg_out, reg_write_out, dmem_en, dmem_wr,
                dmem_addr, dmem_wdata, err};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected 0", outs);
        end
    endtask

    task automatic test_alu();
        issue(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd3);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall: got %b expected 0", stall);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, wb_data, wb_reg_out, reg_write_out, stall} !==
            {1'b1, 16'h1234, 3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL alu_result: got v=%b d=%h r=%0d w=%b s=%b expected v=1 d=1234 r=3 w=1 s=0",
                     out_valid, wb_data, wb_reg_out, reg_write_out, stall);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_strobe_len: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [3];
        vals[0] = 16'h0101;
        vals[1] = 16'hA5A5;
        vals[2] = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            issue(vals[i], 16'h0000, 1'b0, 1'b0, 1'b1, 3'(i + 1));
            step();
            checks++;
            if ({out_valid, wb_data, wb_reg_out, stall} !== {1'b1, vals[i], 3'(i + 1), 1'b0}) begin
                errors++;
                $display("FAIL b2b_%0d: got v=%b d=%h r=%0d s=%b expected v=1 d=%h r=%0d s=0",
                         i, out_valid, wb_data, wb_reg_out, stall, vals[i], i + 1);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_load();
        issue(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd6);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            dmem_ready = (k == 4);
            dmem_rdata = (k == 4) ? 16'hBEEF : 16'($urandom);
            checks++;
            if ({dmem_en, dmem_wr, dmem_addr, stall, out_valid} !==
                {1'b1, 1'b0, 16'h0040, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL load_busy_%0d: got en=%b wr=%b a=%h s=%b v=%b expected en=1 wr=0 a=0040 s=1 v=0",
                         k, dmem_en, dmem_wr, dmem_addr, stall, out_valid);
            end
            step();
        end
        dmem_ready = 1'b0;
        dmem_rdata = 16'h0000;
        checks++;
        if ({out_valid, wb_data, wb_reg_out, reg_write_out, stall, dmem_en} !==
            {1'b1, 16'hBEEF, 3'd6, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_result: got v=%b d=%h r=%0d w=%b s=%b en=%b expected v=1 d=beef r=6 w=1 s=0 en=0",
                     out_valid, wb_data, wb_reg_out, reg_write_out, stall, dmem_en);
        end
        step();
    endtask

    task automatic test_store();
        issue(16'h0010, 16'h00AA, 1'b0, 1'b1, 1'b1, 3'd5);
        step();
        in_valid   = 1'b0;
        dmem_ready = 1'b1;
        checks++;
        if ({dmem_en, dmem_wr, dmem_addr, dmem_wdata, stall} !==
            {1'b1, 1'b1, 16'h0010, 16'h00AA, 1'b1}) begin
            errors++;
            $display("FAIL store_req: got en=%b wr=%b a=%h wd=%h s=%b expected en=1 wr=1 a=0010 wd=00aa s=1",
                     dmem_en, dmem_wr, dmem_addr, dmem_wdata, stall);
        end
        step();
        dmem_ready = 1'b0;
        checks++;
        if ({out_valid, reg_write_out, wb_data, dmem_en} !== {1'b1, 1'b0, 16'h0010, 1'b0}) begin
            errors++;
            $display("FAIL store_done: got v=%b w=%b d=%h en=%b expected v=1 w=0 d=0010 en=0",
                     out_valid, reg_write_out, wb_data, dmem_en);
        end
        step();
    endtask

    task automatic test_timeout();
        issue(16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= int'(MAX_WAIT); k++) begin
            checks++;
            if ({dmem_en, stall, err} !== {1'b1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL timeout_wait_%0d: got en=%b s=%b err=%b expected en=1 s=1 err=0",
                         k, dmem_en, stall, err);
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({err, dmem_en, stall, out_valid} !== {1'b1, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL timeout_err_%0d: got err=%b en=%b s=%b v=%b expected err=1 en=0 s=1 v=0",
                         k, err, dmem_en, stall, out_valid);
            end
            issue(16'h0777, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd2);
            step();
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({err, stall, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_reset: got err=%b s=%b v=%b expected 000", err, stall, out_valid);
        end
        idle_inputs();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_load();
        issue(16'h0080, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd4);
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({dmem_en, stall} !== 2'b11) begin
            errors++;
            $display("FAIL midload_busy: got en=%b s=%b expected 11", dmem_en, stall);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({dmem_en, stall, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL midload_async: got en=%b s=%b v=%b expected 000", dmem_en, stall, out_valid);
        end
        step();
        rst        = 1'b1;
        dmem_ready = 1'b1;
        dmem_rdata = 16'h5A5A;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({out_valid, dmem_en, stall} !== 3'b000) begin
                errors++;
                $display("FAIL midload_late_ready_%0d: got v=%b en=%b s=%b expected 000",
                         k, out_valid, dmem_en, stall);
            end
        end
        dmem_ready = 1'b0;
    endtask

    task automatic test_both_ops();
        issue(16'h0030, 16'h0055, 1'b1, 1'b1, 1'b1, 3'd2);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({err, stall, dmem_en, out_valid} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL both_ops_%0d: got err=%b s=%b en=%b v=%b expected err=1 s=1 en=0 v=0",
                         k, err, stall, dmem_en, out_valid);
            end
            step();
        end
        apply_reset();
    endtask

    task automatic test_align();
        issue(16'h0041, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd7);
`ifdef MEM_ALIGN_CHECK_EN
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({err, dmem_en, stall} !== {1'b1, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL align_trap_%0d: got err=%b en=%b s=%b expected err=1 en=0 s=1",
                         k, err, dmem_en, stall);
            end
            step();
        end
        apply_reset();
`else
        step();
        in_valid   = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 16'h1357;
        checks++;
        if ({dmem_en, dmem_addr, err} !== {1'b1, 16'h0041, 1'b0}) begin
            errors++;
            $display("FAIL odd_addr_req: got en=%b a=%h err=%b expected en=1 a=0041 err=0",
                     dmem_en, dmem_addr, err);
        end
        step();
        dmem_ready = 1'b0;
        checks++;
        if ({out_valid, wb_data} !== {1'b1, 16'h1357}) begin
            errors++;
            $display("FAIL odd_addr_load: got v=%b d=%h expected v=1 d=1357", out_valid, wb_data);
        end
        step();
`endif
    endtask

    // Reference: each legal instruction completes (delay+1) cycles after capture for memory
    // ops, 1 cycle for ALU ops; loads return the memory word, all else the ALU result.
    task automatic test_random();
        int            kind, delay;
        logic [DW-1:0] alu, sd, rdata, exp_data;
        logic [2:0]    rg;
        logic          rw, exp_rw;
        for (int n = 0; n < 60; n++) begin
            kind  = int'($urandom_range(0, 2));
            alu   = 16'($urandom);
            sd    = 16'($urandom);
            rdata = 16'($urandom);
            rg    = 3'($urandom);
            rw    = 1'($urandom);
            delay = int'($urandom_range(1, MAX_WAIT));
`ifdef MEM_ALIGN_CHECK_EN
            if (kind != 0) alu[0] = 1'b0;
`endif
            exp_data = (kind == 1) ? rdata : alu;
            exp_rw   = rw && (kind != 2);
            issue(alu, sd, kind == 1, kind == 2, rw, rg);
            dmem_ready = 1'b0;
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL rnd_accept_%0d: got stall=%b expected 0", n, stall);
            end
            step();
            if (kind != 0) begin
                for (int k = 1; k <= delay; k++) begin
                    in_valid   = 1'($urandom);
                    ALU_out    = 16'($urandom);
                    dmem_ready = (k == delay);
                    dmem_rdata = (k == delay) ? rdata : 16'($urandom);
                    checks++;
                    if ({dmem_en, dmem_wr, dmem_addr, stall, out_valid} !==
                        {1'b1, (kind == 2), alu, 1'b1, 1'b0} ||
                        (kind == 2 && dmem_wdata !== sd)) begin
                        errors++;
                        $display("FAIL rnd_busy_%0d_%0d: got en=%b wr=%b a=%h wd=%h s=%b v=%b expected en=1 wr=%b a=%h wd=%h s=1 v=0",
                                 n, k, dmem_en, dmem_wr, dmem_addr, dmem_wdata, stall, out_valid,
                                 kind == 2, alu, sd);
                    end
                    step();
                end
                dmem_ready = 1'b0;
            end
            in_valid = 1'b0;
            checks++;
            if ({out_valid, wb_data, wb_reg_out, reg_write_out, stall, dmem_en} !==
                {1'b1, exp_data, rg, exp_rw, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rnd_wb_%0d: got v=%b d=%h r=%0d w=%b s=%b en=%b expected v=1 d=%h r=%0d w=%b s=0 en=0",
                         n, out_valid, wb_data, wb_reg_out, reg_write_out, stall, dmem_en,
                         exp_data, rg, exp_rw);
            end
            if ($urandom_range(0, 1) == 1) begin
                dmem_ready = 1'($urandom);
                step();
                checks++;
                if ({out_valid, dmem_en} !== 2'b00) begin
                    errors++;
                    $display("FAIL rnd_gap_%0d: got v=%b en=%b expected 00", n, out_valid, dmem_en);
                end
                dmem_ready = 1'b0;
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_timeout();
        test_reset_mid_load();
        test_both_ops();
        test_align();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
